// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests one ROM word per program-counter value, holds it in the
// instruction register until the executor consumes it, and discards stale words when the
// PC moves on before consumption.
// Optional feature: define IFU_FLUSH_CNT_EN to add the flush_cnt port and discard counter.
// Timing: the ROM address is presented while rom_rd is high and the ROM word arrives in the
// following cycle. The address is therefore registered on the IDLE->REQ transition.
module instr_fetch_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [7:0]  pc,
    output logic        rom_rd,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [15:0] ir,
    output logic [3:0]  opcode,
    output logic [7:0]  operand,
    output logic        ir_valid,
    input  logic        exec_ready,
    output logic [7:0]  fetch_cnt
`ifdef IFU_FLUSH_CNT_EN
    ,
    output logic [7:0]  flush_cnt
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StHold
    } state_t;

    state_t     state;
    logic [7:0] last_addr;
    logic       need_fetch;
    logic       pc_moved;

    assign pc_moved = (pc != last_addr);

    // Decoded fields are always a direct view of the held instruction.
    assign opcode  = ir[15:12];
    assign operand = ir[7:0];

    // Fetch FSM with registered strobe, address, instruction and counters.
    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= StIdle;
            ir         <= 16'h0000;
            ir_valid   <= 1'b0;
            rom_rd     <= 1'b0;
            rom_addr   <= 8'h00;
            last_addr  <= 8'h00;
            need_fetch <= 1'b1;
            fetch_cnt  <= 8'h00;
`ifdef IFU_FLUSH_CNT_EN
            flush_cnt  <= 8'h00;
`endif
        end else begin
            // The strobe is a single-cycle pulse; it is only raised when entering REQ.
            rom_rd <= 1'b0;
            case (state)
                StIdle: begin
                    if (need_fetch || pc_moved) begin
                        state      <= StReq;
                        rom_rd     <= 1'b1;
                        rom_addr   <= pc;
                        last_addr  <= pc;
                        need_fetch <= 1'b0;
                    end
                end
                StReq: begin
                    // PC changes here do not abort; a stale word is flushed from HOLD.
                    state <= StWait;
                end
                StWait: begin
                    ir        <= rom_data;
                    ir_valid  <= 1'b1;
                    fetch_cnt <= fetch_cnt + 8'd1;
                    state     <= StHold;
                end
                StHold: begin
                    if (exec_ready) begin
                        // Consumption wins over a simultaneous PC change: no flush.
                        ir_valid <= 1'b0;
                        state    <= StIdle;
                    end else if (pc_moved) begin
                        ir_valid <= 1'b0;
`ifdef IFU_FLUSH_CNT_EN
                        flush_cnt <= flush_cnt + 8'd1;
`endif
                        state    <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a registered ROM model and a scoreboard
// queue of expected instruction words.
module tb_instr_fetch_unit;

    logic        clk;
    logic        clr;
    logic [7:0]  pc;
    logic        rom_rd;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic [7:0]  operand;
    logic        ir_valid;
    logic        exec_ready;
    logic [7:0]  fetch_cnt;
`ifdef IFU_FLUSH_CNT_EN
    logic [7:0]  flush_cnt;
`endif

    int          checks;
    int          errors;
    logic [15:0] exp_q[$];
    logic [7:0]  exp_fetch;
    logic [7:0]  exp_flush;
    logic        rd_prev;
    int          rd_double;

    instr_fetch_unit dut (
        .clk        (clk),
        .clr        (clr),
        .pc         (pc),
        .rom_rd     (rom_rd),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .ir         (ir),
        .opcode     (opcode),
        .operand    (operand),
        .ir_valid   (ir_valid),
        .exec_ready (exec_ready),
        .fetch_cnt  (fetch_cnt)
`ifdef IFU_FLUSH_CNT_EN
        ,
        .flush_cnt  (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [7:0] a);
        if (a == 8'h00) return 16'hA512;
        return {a ^ 8'hC3, ~a};
    endfunction

    // Registered ROM: word appears the cycle after the strobe.
    always @(posedge clk) begin
        if (rom_rd) rom_data <= rom_word(rom_addr);
    end

    // Watch for back-to-back read strobes.
    always @(negedge clk) begin
        if (clr) begin
            rd_prev <= 1'b0;
        end else begin
            if (rom_rd && rd_prev) rd_double <= rd_double + 1;
            rd_prev <= rom_rd;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        step();
        while (!ir_valid && n < 20) begin
            step();
            n++;
        end
        if (!ir_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: ir_valid timeout, got %0b want 1", name, ir_valid);
        end
    endtask

    task automatic wait_rd(input string name);
        int n;
        n = 0;
        step();
        while (!rom_rd && n < 20) begin
            step();
            n++;
        end
        if (!rom_rd) begin
            checks++;
            errors++;
            $display("FAIL %s: rom_rd timeout, got %0b want 1", name, rom_rd);
        end
    endtask

    task automatic check_word(input string name);
        logic [15:0] w;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected word, got %h want none", name, ir);
            return;
        end
        w = exp_q.pop_front();
        if (ir !== w) begin
            errors++;
            $display("FAIL %s: ir got %h want %h", name, ir, w);
        end
    endtask

    task automatic check_cnts(input string name);
        checks++;
        if (fetch_cnt !== exp_fetch) begin
            errors++;
            $display("FAIL %s: fetch_cnt got %h want %h", name, fetch_cnt, exp_fetch);
        end
`ifdef IFU_FLUSH_CNT_EN
        checks++;
        if (flush_cnt !== exp_flush) begin
            errors++;
            $display("FAIL %s: flush_cnt got %h want %h", name, flush_cnt, exp_flush);
        end
`endif
    endtask

    task automatic consume(input string name);
        exec_ready = 1'b1;
        step();
        exec_ready = 1'b0;
        checks++;
        if (ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s: ir_valid after consume got %b want 0", name, ir_valid);
        end
    endtask

    task automatic test_reset();
        clr        = 1'b1;
        pc         = 8'h00;
        exec_ready = 1'b0;
        step();
        step();
        checks++;
        if (ir !== 16'h0000 || ir_valid !== 1'b0 || rom_rd !== 1'b0 || rom_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset: ir=%h v=%b rd=%b addr=%h want 0000 0 0 00",
                     ir, ir_valid, rom_rd, rom_addr);
        end
        exp_fetch = 8'h00;
        exp_flush = 8'h00;
        check_cnts("reset_cnt");
    endtask

    task automatic test_first_fetch();
        exp_q.push_back(rom_word(8'h00));
        clr = 1'b0;
        step();
        checks++;
        if (rom_rd !== 1'b1 || rom_addr !== 8'h00) begin
            errors++;
            $display("FAIL first_rd: rd=%b addr=%h want 1 00", rom_rd, rom_addr);
        end
        step();
        checks++;
        if (rom_rd !== 1'b0 || ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_wait: rd=%b v=%b want 0 0", rom_rd, ir_valid);
        end
        step();
        checks++;
        if (ir_valid !== 1'b1 || opcode !== 4'hA || operand !== 8'h12) begin
            errors++;
            $display("FAIL first_hold: v=%b op=%h opd=%h want 1 a 12", ir_valid, opcode, operand);
        end
        check_word("first_word");
        exp_fetch++;
        check_cnts("first_cnt");
    endtask

    task automatic test_no_refetch();
        int rds;
        consume("consume0");
        rds = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rom_rd) rds++;
        end
        checks++;
        if (rds != 0 || ir !== 16'hA512 || ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_refetch: rds=%0d ir=%h v=%b want 0 a512 0", rds, ir, ir_valid);
        end
    endtask

    task automatic test_flush();
        pc = 8'h05;
        exp_q.push_back(rom_word(8'h05));
        wait_valid("flush_pc5");
        check_word("flush_word5");
        exp_fetch++;
        pc = 8'h06;
        step();
        checks++;
        if (ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop: ir_valid got %b want 0", ir_valid);
        end
        exp_flush++;
        check_cnts("flush_cnt1");
        exp_q.push_back(rom_word(8'h06));
        wait_valid("flush_pc6");
        check_word("flush_word6");
        exp_fetch++;
        check_cnts("flush_cnt2");
        consume("consume6");
    endtask

    task automatic test_stale();
        pc = 8'h10;
        exp_q.push_back(rom_word(8'h10));
        exp_q.push_back(rom_word(8'h11));
        wait_rd("stale_rd");
        step();
        pc = 8'h11;
        wait_valid("stale_v10");
        check_word("stale_word10");
        exp_fetch++;
        step();
        checks++;
        if (ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_drop: ir_valid got %b want 0", ir_valid);
        end
        exp_flush++;
        wait_valid("stale_v11");
        check_word("stale_word11");
        exp_fetch++;
        check_cnts("stale_cnt");
        consume("consume11");
    endtask

    task automatic test_clr_mid();
        pc = 8'h20;
        wait_rd("clr_rd");
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if (ir !== 16'h0000 || ir_valid !== 1'b0 || rom_rd !== 1'b0) begin
            errors++;
            $display("FAIL clr_mid: ir=%h v=%b rd=%b want 0000 0 0", ir, ir_valid, rom_rd);
        end
        exp_fetch = 8'h00;
        exp_flush = 8'h00;
        check_cnts("clr_cnt");
        exp_q.delete();
        exp_q.push_back(rom_word(8'h20));
        wait_valid("clr_refetch");
        check_word("clr_word");
        exp_fetch++;
        check_cnts("clr_cnt2");
        consume("consume20");
    endtask

    task automatic test_back_to_back();
        logic [7:0] p;
        for (int i = 0; i < 256; i++) begin
            p = 8'h21 + i[7:0];
            pc = p;
            exp_q.push_back(rom_word(p));
            wait_valid("b2b_valid");
            check_word("b2b_word");
            exp_fetch++;
            check_cnts("b2b_cnt");
            consume("b2b_consume");
        end
        checks++;
        if (fetch_cnt !== 8'h01) begin
            errors++;
            $display("FAIL b2b_wrap: fetch_cnt got %h want 01", fetch_cnt);
        end
        checks++;
        if (rd_double != 0) begin
            errors++;
            $display("FAIL b2b_rd_double: got %0d want 0", rd_double);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rd_double  = 0;
        rd_prev    = 1'b0;
        rom_data   = 16'h0000;
        clr        = 1'b1;
        pc         = 8'h00;
        exec_ready = 1'b0;
        test_reset();
        test_first_fetch();
        test_no_refetch();
        test_flush();
        test_stale();
        test_clr_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
